// File: rtl/prim_alert_hs_monitor.sv
// Passive observer for differential alert channels. It flags wire-pair integrity, handshake
// order/liveness and ping latency violations as sticky bits, and counts the error cycles.
module prim_alert_hs_monitor #(
  parameter int unsigned NumAlerts   = 4,
  parameter int unsigned PingTimeout = 9,
  parameter int unsigned HsTimeout   = 16,
  parameter int unsigned CntW        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumAlerts-1:0] alert_p_i,
  input  logic [NumAlerts-1:0] alert_n_i,
  input  logic [NumAlerts-1:0] ack_p_i,
  input  logic [NumAlerts-1:0] ack_n_i,
  input  logic [NumAlerts-1:0] ping_p_i,
  input  logic [NumAlerts-1:0] ping_n_i,
  input  logic [NumAlerts-1:0] ping_en_i,
  input  logic [NumAlerts-1:0] ping_ok_i,
  input  logic                 clr_i,
  output logic [NumAlerts-1:0] integ_err_o,
  output logic [NumAlerts-1:0] proto_err_o,
  output logic [NumAlerts-1:0] ping_err_o,
  output logic [NumAlerts-1:0] hs_done_o,
  output logic [CntW-1:0]      err_cnt_o,
  output logic                 any_err_o
);

  localparam int unsigned DwellW = $clog2(HsTimeout + 1);
  localparam int unsigned PingW  = $clog2(PingTimeout + 1);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(HsTimeout - 1);
  localparam logic [PingW-1:0]  PingMax  = PingW'(PingTimeout - 1);
  localparam logic [CntW-1:0]   CntMax   = {CntW{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StAlertHi,
    StAckHi,
    StAlertLo,
    StResync
  } hs_state_e;

  hs_state_e            state_q    [NumAlerts];
  hs_state_e            state_d    [NumAlerts];
  logic [DwellW-1:0]    dwell_q    [NumAlerts];
  logic [DwellW-1:0]    dwell_d    [NumAlerts];
  logic [PingW-1:0]     ping_cnt_q [NumAlerts];
  logic [PingW-1:0]     ping_cnt_d [NumAlerts];

  logic [NumAlerts-1:0] integ_ev, proto_ev, ping_ev, done_ev, hs_stay;
  logic [NumAlerts-1:0] ping_pend_q, ping_pend_d, ping_en_q;
  logic [NumAlerts-1:0] integ_err_q, integ_err_d;
  logic [NumAlerts-1:0] proto_err_q, proto_err_d;
  logic [NumAlerts-1:0] ping_err_q, ping_err_d;
  logic [NumAlerts-1:0] hs_done_q;
  logic [CntW-1:0]      err_cnt_q, err_cnt_d, err_cnt_base;
  logic                 any_err_q, any_err_d;
  logic                 ev_any;

  // Handshake tracking: integrity loss overrides everything and parks the channel in Resync.
  always_comb begin
    for (int i = 0; i < NumAlerts; i++) begin
      integ_ev[i] = (alert_p_i[i] == alert_n_i[i]) | (ack_p_i[i] == ack_n_i[i]) |
                    (ping_p_i[i] == ping_n_i[i]);
      proto_ev[i] = 1'b0;
      done_ev[i]  = 1'b0;
      hs_stay[i]  = 1'b0;
      state_d[i]  = state_q[i];
      dwell_d[i]  = '0;
      if (integ_ev[i]) begin
        state_d[i] = StResync;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (ack_p_i[i]) begin
              proto_ev[i] = 1'b1;
              state_d[i]  = StResync;
            end else if (alert_p_i[i]) begin
              state_d[i] = StAlertHi;
            end
          end
          StAlertHi: begin
            if (!alert_p_i[i]) begin
              proto_ev[i] = 1'b1;
              state_d[i]  = StResync;
            end else if (ack_p_i[i]) begin
              state_d[i] = StAckHi;
            end else begin
              hs_stay[i] = 1'b1;
            end
          end
          StAckHi: begin
            if (!ack_p_i[i]) begin
              proto_ev[i] = 1'b1;
              state_d[i]  = StResync;
            end else if (!alert_p_i[i]) begin
              state_d[i] = StAlertLo;
            end else begin
              hs_stay[i] = 1'b1;
            end
          end
          StAlertLo: begin
            if (alert_p_i[i]) begin
              proto_ev[i] = 1'b1;
              state_d[i]  = StResync;
            end else if (!ack_p_i[i]) begin
              state_d[i] = StIdle;
              done_ev[i] = 1'b1;
            end else begin
              hs_stay[i] = 1'b1;
            end
          end
          StResync: begin
            if (!alert_p_i[i] && !ack_p_i[i]) begin
              state_d[i] = StIdle;
            end
          end
          default: state_d[i] = StResync;
        endcase
        // A handshake that makes no progress for HsTimeout cycles is a liveness failure.
        if (hs_stay[i]) begin
          if (dwell_q[i] == DwellMax) begin
            proto_ev[i] = 1'b1;
            state_d[i]  = StResync;
          end else begin
            dwell_d[i] = dwell_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Ping latency: a rising request opens a window of PingTimeout cycles for ping_ok.
  always_comb begin
    for (int i = 0; i < NumAlerts; i++) begin
      ping_ev[i]     = 1'b0;
      ping_pend_d[i] = ping_pend_q[i];
      ping_cnt_d[i]  = ping_cnt_q[i];
      if (ping_pend_q[i]) begin
        if (ping_ok_i[i]) begin
          ping_pend_d[i] = 1'b0;
        end else if (!ping_en_i[i] || (ping_cnt_q[i] == PingMax)) begin
          ping_ev[i]     = 1'b1;
          ping_pend_d[i] = 1'b0;
        end else begin
          ping_cnt_d[i] = ping_cnt_q[i] + 1'b1;
        end
      end else begin
        if (ping_ok_i[i]) begin
          ping_ev[i] = 1'b1;
        end
        if (ping_en_i[i] && !ping_en_q[i]) begin
          ping_pend_d[i] = 1'b1;
          ping_cnt_d[i]  = '0;
        end
      end
    end
  end

  // New events win over a coincident clear.
  always_comb begin
    ev_any       = |{integ_ev, proto_ev, ping_ev};
    integ_err_d  = (clr_i ? '0 : integ_err_q) | integ_ev;
    proto_err_d  = (clr_i ? '0 : proto_err_q) | proto_ev;
    ping_err_d   = (clr_i ? '0 : ping_err_q) | ping_ev;
    err_cnt_base = clr_i ? '0 : err_cnt_q;
    err_cnt_d    = err_cnt_base;
    if (ev_any && (err_cnt_base != CntMax)) begin
      err_cnt_d = err_cnt_base + 1'b1;
    end
    any_err_d = |{integ_err_d, proto_err_d, ping_err_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumAlerts; i++) begin
        state_q[i]    <= StIdle;
        dwell_q[i]    <= '0;
        ping_cnt_q[i] <= '0;
      end
      ping_pend_q <= '0;
      ping_en_q   <= '0;
      integ_err_q <= '0;
      proto_err_q <= '0;
      ping_err_q  <= '0;
      hs_done_q   <= '0;
      err_cnt_q   <= '0;
      any_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumAlerts; i++) begin
        state_q[i]    <= state_d[i];
        dwell_q[i]    <= dwell_d[i];
        ping_cnt_q[i] <= ping_cnt_d[i];
      end
      ping_pend_q <= ping_pend_d;
      ping_en_q   <= ping_en_i;
      integ_err_q <= integ_err_d;
      proto_err_q <= proto_err_d;
      ping_err_q  <= ping_err_d;
      hs_done_q   <= done_ev;
      err_cnt_q   <= err_cnt_d;
      any_err_q   <= any_err_d;
    end
  end

  assign integ_err_o = integ_err_q;
  assign proto_err_o = proto_err_q;
  assign ping_err_o  = ping_err_q;
  assign hs_done_o   = hs_done_q;
  assign err_cnt_o   = err_cnt_q;
  assign any_err_o   = any_err_q;

endmodule

// File: tb/tb_prim_alert_hs_monitor.sv
// Bench for prim_alert_hs_monitor: directed scenarios plus randomized traffic checked
// against a sequence/deadline reference model.
module tb_prim_alert_hs_monitor;
  localparam int unsigned N  = 4;
  localparam int unsigned PT = 9;
  localparam int unsigned HT = 16;
  localparam int unsigned CW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] alert_p, alert_n, ack_p, ack_n, ping_p, ping_n, ping_en, ping_ok;
  logic         clr;
  logic [N-1:0] integ_err, proto_err, ping_err, hs_done;
  logic [CW-1:0] err_cnt;
  logic         any_err;
  logic [N-1:0] s_integ, s_proto, s_ping, s_done;
  logic [1:0]   s_cnt;
  logic         s_any;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int           phase    [N];
  bit           resync   [N];
  int           dwell    [N];
  bit           pend     [N];
  int           deadline [N];
  bit           en_prev  [N];
  int           cyc = 0;
  logic [N-1:0] e_integ, e_proto, e_ping, e_done;
  int           e_cnt, e_cnt_sat;
  logic         e_any;

  prim_alert_hs_monitor #(.NumAlerts(N), .PingTimeout(PT), .HsTimeout(HT), .CntW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .alert_p_i(alert_p), .alert_n_i(alert_n), .ack_p_i(ack_p),
    .ack_n_i(ack_n), .ping_p_i(ping_p), .ping_n_i(ping_n), .ping_en_i(ping_en),
    .ping_ok_i(ping_ok), .clr_i(clr), .integ_err_o(integ_err), .proto_err_o(proto_err),
    .ping_err_o(ping_err), .hs_done_o(hs_done), .err_cnt_o(err_cnt), .any_err_o(any_err)
  );

  prim_alert_hs_monitor #(.NumAlerts(N), .PingTimeout(PT), .HsTimeout(HT), .CntW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .alert_p_i(alert_p), .alert_n_i(alert_n), .ack_p_i(ack_p),
    .ack_n_i(ack_n), .ping_p_i(ping_p), .ping_n_i(ping_n), .ping_en_i(ping_en),
    .ping_ok_i(ping_ok), .clr_i(clr), .integ_err_o(s_integ), .proto_err_o(s_proto),
    .ping_err_o(s_ping), .hs_done_o(s_done), .err_cnt_o(s_cnt), .any_err_o(s_any)
  );

  always #5 clk = ~clk;

  // Legal (alert_p, ack_p) sequence: (0,0) -> (1,0) -> (1,1) -> (0,1) -> (0,0)
  function automatic logic [1:0] pat(int ph);
    return {(ph == 1 || ph == 2), (ph == 2 || ph == 3)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      phase[i] = 0; resync[i] = 0; dwell[i] = 0; pend[i] = 0; deadline[i] = 0; en_prev[i] = 0;
    end
    e_integ = '0; e_proto = '0; e_ping = '0; e_done = '0;
    e_cnt = 0; e_cnt_sat = 0; e_any = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] ei, ep, eg, ed;
    logic [1:0]   cur;
    ei = '0; ep = '0; eg = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      ei[i] = (alert_p[i] == alert_n[i]) || (ack_p[i] == ack_n[i]) || (ping_p[i] == ping_n[i]);
      cur   = {alert_p[i], ack_p[i]};
      if (ei[i]) begin
        resync[i] = 1; phase[i] = 0; dwell[i] = 0;
      end else if (resync[i]) begin
        if (cur == 2'b00) resync[i] = 0;
      end else if (cur == pat(phase[i])) begin
        if (phase[i] != 0) begin
          if (dwell[i] == HT - 1) begin
            ep[i] = 1; resync[i] = 1; phase[i] = 0; dwell[i] = 0;
          end else begin
            dwell[i]++;
          end
        end
      end else if (cur == pat((phase[i] + 1) % 4)) begin
        phase[i] = (phase[i] + 1) % 4;
        dwell[i] = 0;
        if (phase[i] == 0) ed[i] = 1;
      end else begin
        ep[i] = 1; resync[i] = 1; phase[i] = 0; dwell[i] = 0;
      end
      if (pend[i]) begin
        if (ping_ok[i]) pend[i] = 0;
        else if (!ping_en[i] || cyc == deadline[i]) begin
          eg[i] = 1; pend[i] = 0;
        end
      end else begin
        if (ping_ok[i]) eg[i] = 1;
        if (ping_en[i] && !en_prev[i]) begin
          pend[i] = 1; deadline[i] = cyc + PT;
        end
      end
      en_prev[i] = ping_en[i];
    end
    e_integ = (clr ? '0 : e_integ) | ei;
    e_proto = (clr ? '0 : e_proto) | ep;
    e_ping  = (clr ? '0 : e_ping) | eg;
    e_done  = ed;
    if (clr) begin
      e_cnt = 0; e_cnt_sat = 0;
    end
    if ((ei | ep | eg) != '0) begin
      if (e_cnt < (1 << CW) - 1) e_cnt++;
      if (e_cnt_sat < 3) e_cnt_sat++;
    end
    e_any = |{e_integ, e_proto, e_ping};
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alert_p = '0; alert_n = '1; ack_p = '0; ack_n = '1; ping_p = '0; ping_n = '1;
    ping_en = '0; ping_ok = '0; clr = 1'b0;
  endtask

  task automatic set_alert(int ch, logic v);
    alert_p[ch] = v; alert_n[ch] = ~v;
  endtask

  task automatic set_ack(int ch, logic v);
    ack_p[ch] = v; ack_n[ch] = ~v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({integ_err, proto_err, ping_err, hs_done} !== '0)
      $display("FAIL reset_flags: got %h want 0", {integ_err, proto_err, ping_err, hs_done});
    else n_pass++;
    n_chk++;
    if (err_cnt !== '0 || s_cnt !== '0) $display("FAIL reset_cnt: got %0d/%0d want 0", err_cnt, s_cnt);
    else n_pass++;
    n_chk++;
    if (any_err !== 1'b0) $display("FAIL reset_any: got %b want 0", any_err);
    else n_pass++;
  endtask

  task automatic test_handshake();
    do_reset();
    set_alert(0, 1); tick();
    set_ack(0, 1);   tick();
    set_alert(0, 0); tick();
    n_chk++;
    if (hs_done !== 4'b0000) $display("FAIL hs_early: got %b want 0000", hs_done);
    else n_pass++;
    set_ack(0, 0);   tick();
    n_chk++;
    if (hs_done !== 4'b0001) $display("FAIL hs_done: got %b want 0001", hs_done);
    else n_pass++;
    n_chk++;
    if ({integ_err, proto_err, ping_err} !== '0 || err_cnt !== 0)
      $display("FAIL hs_clean: got flags %h cnt %0d want 0 0",
               {integ_err, proto_err, ping_err}, err_cnt);
    else n_pass++;
    tick();
    n_chk++;
    if (hs_done !== 4'b0000) $display("FAIL hs_pulse: got %b want 0000", hs_done);
    else n_pass++;
  endtask

  task automatic test_integrity();
    do_reset();
    alert_p[2] = 1'b1; alert_n[2] = 1'b1; tick();
    n_chk++;
    if (integ_err !== 4'b0100 || err_cnt !== 1 || proto_err !== '0)
      $display("FAIL integ_set: got integ %b proto %b cnt %0d want 0100 0000 1",
               integ_err, proto_err, err_cnt);
    else n_pass++;
    set_alert(2, 0); tick();
    set_alert(2, 1); tick();
    set_ack(2, 1);   tick();
    set_alert(2, 0); tick();
    set_ack(2, 0);   tick();
    n_chk++;
    if (hs_done !== 4'b0100 || integ_err !== 4'b0100 || err_cnt !== 1)
      $display("FAIL integ_resync: got done %b integ %b cnt %0d want 0100 0100 1",
               hs_done, integ_err, err_cnt);
    else n_pass++;
  endtask

  task automatic test_order();
    do_reset();
    set_ack(1, 1); tick();
    n_chk++;
    if (proto_err !== 4'b0010 || err_cnt !== 1)
      $display("FAIL order_idle_ack: got %b cnt %0d want 0010 1", proto_err, err_cnt);
    else n_pass++;
    set_ack(1, 0); clr = 1'b1; tick();
    clr = 1'b0;
    n_chk++;
    if (proto_err !== '0 || err_cnt !== 0 || any_err !== 1'b0)
      $display("FAIL order_clr: got %b cnt %0d any %b want 0000 0 0", proto_err, err_cnt, any_err);
    else n_pass++;
    set_alert(1, 1); tick();
    for (int k = 0; k < HT - 1; k++) tick();
    n_chk++;
    if (proto_err !== '0) $display("FAIL dwell_early: got %b want 0000", proto_err);
    else n_pass++;
    tick();
    n_chk++;
    if (proto_err !== 4'b0010 || err_cnt !== 1)
      $display("FAIL dwell_timeout: got %b cnt %0d want 0010 1", proto_err, err_cnt);
    else n_pass++;
    // Alert still high in Resync must not raise further errors
    for (int k = 0; k < 3; k++) tick();
    n_chk++;
    if (err_cnt !== 1) $display("FAIL resync_quiet: got cnt %0d want 1", err_cnt);
    else n_pass++;
    set_alert(1, 0); tick();
  endtask

  task automatic test_ping();
    do_reset();
    ping_en[0] = 1'b1; tick();
    for (int k = 0; k < PT - 1; k++) tick();
    ping_ok[0] = 1'b1; tick();
    ping_ok[0] = 1'b0;
    n_chk++;
    if (ping_err !== '0) $display("FAIL ping_last_ok: got %b want 0000", ping_err);
    else n_pass++;
    ping_en[0] = 1'b0; tick();
    ping_en[0] = 1'b1; tick();
    for (int k = 0; k < PT - 1; k++) tick();
    n_chk++;
    if (ping_err !== '0) $display("FAIL ping_before_to: got %b want 0000", ping_err);
    else n_pass++;
    tick();
    n_chk++;
    if (ping_err !== 4'b0001 || err_cnt !== 1)
      $display("FAIL ping_timeout: got %b cnt %0d want 0001 1", ping_err, err_cnt);
    else n_pass++;
    ping_en[0] = 1'b0; clr = 1'b1; tick();
    clr = 1'b0;
    ping_en[0] = 1'b1; tick(); tick(); tick();
    ping_en[0] = 1'b0; tick();
    n_chk++;
    if (ping_err !== 4'b0001 || err_cnt !== 1)
      $display("FAIL ping_withdraw: got %b cnt %0d want 0001 1", ping_err, err_cnt);
    else n_pass++;
    clr = 1'b1; tick();
    clr = 1'b0; ping_ok[3] = 1'b1; tick();
    ping_ok[3] = 1'b0;
    n_chk++;
    if (ping_err !== 4'b1000) $display("FAIL ping_unsolicited: got %b want 1000", ping_err);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_ack(0, 1);
    alert_n[3] = 1'b0;
    tick();
    n_chk++;
    if (err_cnt !== 1 || proto_err !== 4'b0001 || integ_err !== 4'b1000)
      $display("FAIL simul: got cnt %0d proto %b integ %b want 1 0001 1000",
               err_cnt, proto_err, integ_err);
    else n_pass++;
    set_idle();
    ping_ok[1] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    ping_ok[1] = 1'b0;
    n_chk++;
    if (err_cnt !== 5 || s_cnt !== 2'd3)
      $display("FAIL saturate: got %0d/%0d want 5/3", err_cnt, s_cnt);
    else n_pass++;
  endtask

  task automatic test_clear();
    do_reset();
    ping_p[2] = 1'b1; tick();
    set_idle();
    clr = 1'b1; set_ack(1, 1); tick();
    clr = 1'b0;
    n_chk++;
    if (proto_err !== 4'b0010 || err_cnt !== 1 || integ_err !== '0 || ping_err !== '0 ||
        any_err !== 1'b1)
      $display("FAIL clr_vs_event: got proto %b cnt %0d integ %b ping %b any %b want 0010 1 0 0 1",
               proto_err, err_cnt, integ_err, ping_err, any_err);
    else n_pass++;
    set_ack(1, 0); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ack(3, 1); tick();
    set_ack(3, 0);
    set_alert(0, 1); tick();
    set_ack(0, 1);   tick();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({integ_err, proto_err, ping_err, hs_done} !== '0 || err_cnt !== 0 || any_err !== 1'b0)
      $display("FAIL reset_async: got flags %h cnt %0d any %b want 0",
               {integ_err, proto_err, ping_err, hs_done}, err_cnt, any_err);
    else n_pass++;
    set_idle();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    set_alert(0, 1); tick();
    set_ack(0, 1);   tick();
    set_alert(0, 0); tick();
    set_ack(0, 0);   tick();
    n_chk++;
    if (hs_done !== 4'b0001 || proto_err !== '0)
      $display("FAIL reset_idle: got done %b proto %b want 0001 0000", hs_done, proto_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int dp [N];
    int slow;
    slow = 0;
    do_reset();
    for (int i = 0; i < N; i++) dp[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) slow = int'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        logic [1:0] ak;
        if ($urandom_range(0, (slow != 0) ? 29 : 1) == 0) dp[i] = (dp[i] + 1) % 4;
        ak = pat(dp[i]);
        if ($urandom_range(0, 24) == 0) ak = 2'($urandom);
        alert_p[i] = ak[1];
        ack_p[i]   = ak[0];
        alert_n[i] = ~ak[1] ^ ($urandom_range(0, 59) == 0);
        ack_n[i]   = ~ak[0] ^ ($urandom_range(0, 59) == 0);
        ping_p[i]  = 1'($urandom);
        ping_n[i]  = ~ping_p[i] ^ ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 11) == 0) ping_en[i] = ~ping_en[i];
        ping_ok[i] = ($urandom_range(0, 9) == 0);
      end
      clr = ($urandom_range(0, 49) == 0);
      tick();
      n_chk++;
      if ({integ_err, proto_err, ping_err} !== {e_integ, e_proto, e_ping})
        $display("FAIL rnd_flags c%0d: got %h want %h", c,
                 {integ_err, proto_err, ping_err}, {e_integ, e_proto, e_ping});
      else n_pass++;
      n_chk++;
      if (hs_done !== e_done) $display("FAIL rnd_done c%0d: got %b want %b", c, hs_done, e_done);
      else n_pass++;
      n_chk++;
      if (err_cnt !== 8'(e_cnt) || s_cnt !== 2'(e_cnt_sat))
        $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, err_cnt, s_cnt, e_cnt, e_cnt_sat);
      else n_pass++;
      n_chk++;
      if (any_err !== e_any) $display("FAIL rnd_any c%0d: got %b want %b", c, any_err, e_any);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_integrity();
    test_order();
    test_ping();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prim_alert_hs_monitor.md
# prim_alert_hs_monitor

Synthesizable, parametrised runtime monitor for `NumAlerts` differential alert channels. It observes each channel's alert, ack and ping wire pairs together with the ping request and ping response, and checks three things:
- differential integrity of each wire pair;
- the four-phase alert/ack handshake ordering;
- handshake liveness and ping response latency.

It turns the pairwise formal properties of the alert sender/receiver pair into sticky, countable silicon error flags. It sits beside the alert receivers in the alert handler, purely as an observer; it never drives the alert wires.

## Interface
Parameters:
- NumAlerts, 4, number of monitored channels (1..32)
- PingTimeout, 9, cycles after ping request rise within which ping_ok must arrive (>=1)
- HsTimeout, 16, max cycles a handshake may dwell in any non-Idle state (>=2)
- CntW, 8, error event counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- alert_p_i, alert_n_i  in  NumAlerts  observed alert differential pair per channel
- ack_p_i, ack_n_i  in  NumAlerts  observed ack differential pair
- ping_p_i, ping_n_i  in  NumAlerts  observed ping differential pair
- ping_en_i  in  NumAlerts  ping request level per channel
- ping_ok_i  in  NumAlerts  ping response pulse per channel
- clr_i  in  1  clears all sticky flags and err_cnt_o
- integ_err_o  out  NumAlerts  sticky differential integrity error
- proto_err_o  out  NumAlerts  sticky handshake order or liveness error
- ping_err_o  out  NumAlerts  sticky ping timeout or early ping withdrawal
- hs_done_o  out  NumAlerts  1-cycle pulse on completed handshake
- err_cnt_o  out  CntW  saturating count of cycles containing ≥1 new error event
- any_err_o  out  1  OR of all sticky flags

## Operation
- All inputs are synchronous to clk_i. No internal synchronisers.
- Integrity check, per channel:
  - event when alert_p==alert_n, ack_p==ack_n or ping_p==ping_n;
  - sets integ_err_o[i];
  - forces that channel's FSM to Resync.
- Handshake FSM, per channel, level-based on (alert_p, ack_p):
  - Idle: (1,0)→AlertHi. Ack high (x,1)→proto error, Resync.
  - AlertHi: (1,1)→AckHi. (1,0) stay. Alert low (0,x)→proto error.
  - AckHi: (0,1)→AlertLo. (1,1) stay. Ack low (x,0)→proto error.
  - AlertLo: (0,0)→Idle with hs_done_o pulse. (0,1) stay. Alert high (1,x)→proto error.
  - Resync: (0,0) with integrity ok→Idle. Otherwise stay. No further proto errors are raised in Resync.
- Dwell counter, per channel:
  - clears on every state change;
  - counts while in AlertHi/AckHi/AlertLo;
  - reaching HsTimeout→proto error, Resync.
- Ping check, per channel:
  - a rise of ping_en_i (registered previous value 0, current 1) in cycle t sets pending and clears the ping counter;
  - while pending, ping_ok_i ends pending with no error;
  - while pending, ping_en_i low without ping_ok_i→ping error;
  - otherwise, at counter == PingTimeout-1→ping error, pending ends; else the counter increments;
  - ping_ok_i while not pending→ping error.
- Counter and clear:
  - err_cnt_o increments by 1 per cycle in which any channel raises any new error event, and saturates at 2^CntW-1.
  - clr_i clears sticky flags and the counter.
  - If clr_i coincides with an event, the event wins: flag=1, err_cnt_o=1.
  - clr_i does not affect FSM, dwell counter or ping state.

## Timing
- Reset values: all outputs 0; FSMs Idle; ping pending 0; previous ping_en 0.
- Input condition in cycle t → flag/pulse visible in cycle t+1 (one register stage). err_cnt_o and any_err_o are also visible in t+1.
- Fastest legal handshake: alert rise at t, ack rise t+1, alert fall t+2, ack fall t+3 → hs_done_o high in t+4.
- Ping: ping_en rise at t. ping_ok accepted in t+1..t+PingTimeout. If none arrives, ping_err_o goes high at t+PingTimeout+1.
- Dwell: entering a non-Idle state at t with no progress → proto_err_o at t+HsTimeout+1.
- Multiple channels erring in one cycle count as a single increment.
- Reset mid-handshake returns to Idle immediately, asynchronously.

## Test plan
- Clean handshake, ch0: alert (1,0)@t, (1,1)@t+1, (0,1)@t+2, (0,0)@t+3 → hs_done_o[0]@t+4, no flags, err_cnt_o=0.
- Integrity: ch2 alert_p=alert_n=1 for 1 cycle at t → integ_err_o[2]@t+1, err_cnt_o=1, FSM Resync. After both wires return to 0 with integrity ok, a new clean handshake produces hs_done_o[2].
- Order error: ch1 ack_p rises in Idle at t → proto_err_o[1]@t+1. Stall in AlertHi for HsTimeout cycles → proto_err_o.
- Ping, defaults: ping_en rise at t with ping_ok@t+9 → no error. Repeat with no ping_ok → ping_err_o@t+10. Drop ping_en at t+3 → ping_err_o@t+4.
- Simultaneous events: ch0 and ch3 error in the same cycle → err_cnt_o +1. Saturation check with CntW=2: 5 error cycles → err_cnt_o=3.
- clr_i coinciding with a new ch1 error → proto_err_o[1]=1, err_cnt_o=1, other flags 0. Assert rst_i mid-handshake → all outputs 0 immediately.
